ahb_burst_sequencer: RTL

AHB-Lite master-side burst sequencer that turns one command (start address, burst type, size, direction, length) into a legal pipelined AHB-Lite transfer sequence on HTRANS/HADDR/HBURST/HSIZE/HWRITE/HWDATA. It sits between a local requester (test driver or DMA-style client) and the AHB-Lite slave/mux fabric. It handles wait states, WRAP and INCR address generation, 1 KB boundary splitting and two-cycle ERROR responses.

---
 rtl/ahb_burst_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ahb_burst_sequencer.sv
// rtl/ahb_burst_sequencer.sv - AHB-Lite master burst sequencer
// Expands one command into a pipelined AHB-Lite burst with wait, wrap, 1 KB split and ERROR handling.
module ahb_burst_sequencer #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [2:0]           cmd_burst,
    input  logic [2:0]           cmd_size,
    input  logic                 cmd_write,
    input  logic [4:0]           cmd_len,
    input  logic [DATAWIDTH-1:0] wr_data,
    output logic                 wr_data_ack,
    output logic [DATAWIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 done,
    output logic                 err,
    output logic [ADDRWIDTH-1:0] HADDR,
    output logic [1:0]           HTRANS,
    output logic [2:0]           HBURST,
    output logic [2:0]           HSIZE,
    output logic                 HWRITE,
    output logic [DATAWIDTH-1:0] HWDATA,
    input  logic [DATAWIDTH-1:0] HRDATA,
    input  logic                 HREADY,
    input  logic                 HRESP
);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR2} state_t;

    state_t                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   haddr_q, haddr_d;
    logic [1:0]             htrans_q, htrans_d;
    logic [2:0]             hburst_q, hburst_d;
    logic [2:0]             hsize_q, hsize_d;
    logic                   hwrite_q, hwrite_d;
    logic [DATAWIDTH-1:0]   hwdata_q, hwdata_d;
    logic [DATAWIDTH-1:0]   rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   wrap_q, wrap_d;
    logic [6:0]             wrap_mask_q, wrap_mask_d;
    logic [4:0]             beats_left_q, beats_left_d;

    logic [1:0]             size_c;
    logic [4:0]             beats_c;
    logic [ADDRWIDTH-1:0]   lsb_mask_c, addr_al_c;
    logic [6:0]             span_c;
    logic                   wrap_c, fixed_c, crosses_c;
    logic [ADDRWIDTH-1:0]   inc_addr_c, mask_ext_c, next_addr_c;
    logic [1:0]             next_trans_c;
    logic                   advance;

    // Command decode: clamp size, derive beat count, align address, detect 1 KB crossing.
    always_comb begin
        size_c = (cmd_size > 3'd2) ? 2'd2 : cmd_size[1:0];
        case (cmd_burst)
            3'b000:         beats_c = 5'd1;
            3'b001:         beats_c = (cmd_len == 5'd0) ? 5'd1 : (cmd_len > 5'd16) ? 5'd16 : cmd_len;
            3'b010, 3'b011: beats_c = 5'd4;
            3'b100, 3'b101: beats_c = 5'd8;
            default:        beats_c = 5'd16;
        endcase
        lsb_mask_c      = '0;
        lsb_mask_c[1:0] = (size_c == 2'd2) ? 2'b11 : (size_c == 2'd1) ? 2'b01 : 2'b00;
        addr_al_c       = cmd_addr & ~lsb_mask_c;
        span_c          = {2'b00, beats_c} << size_c;
        wrap_c          = ~cmd_burst[0] & |cmd_burst[2:1];
        fixed_c         = cmd_burst[0] & |cmd_burst[2:1];
        crosses_c       = ({1'b0, addr_al_c[9:0]} + {4'b0000, span_c}) > 11'd1024;
    end

    // Wrapping beats keep the bits above the wrap window; incrementing beats landing on 1 KB restart as NONSEQ.
    always_comb begin
        inc_addr_c   = haddr_q + (ADDRWIDTH'(1) << hsize_q);
        mask_ext_c   = {{(ADDRWIDTH-7){1'b0}}, wrap_mask_q};
        next_addr_c  = wrap_q ? ((haddr_q & ~mask_ext_c) | (inc_addr_c & mask_ext_c)) : inc_addr_c;
        next_trans_c = (!wrap_q && next_addr_c[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
    end

    always_comb begin
        state_d      = state_q;
        haddr_d      = haddr_q;
        htrans_d     = htrans_q;
        hburst_d     = hburst_q;
        hsize_d      = hsize_q;
        hwrite_d     = hwrite_q;
        hwdata_d     = hwdata_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        wrap_d       = wrap_q;
        wrap_mask_d  = wrap_mask_q;
        beats_left_d = beats_left_q;
        advance      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    haddr_d      = addr_al_c;
                    htrans_d     = TR_NONSEQ;
                    hburst_d     = (fixed_c && crosses_c) ? 3'b001 : cmd_burst;
                    hsize_d      = {1'b0, size_c};
                    hwrite_d     = cmd_write;
                    wrap_d       = wrap_c;
                    wrap_mask_d  = span_c - 7'd1;
                    beats_left_d = beats_c - 5'd1;
                    state_d      = S_ADDR;
                end
            end
            S_ADDR: begin
                advance = HREADY;
            end
            S_BURST, S_LAST: begin
                if (HRESP) begin
                    htrans_d = TR_IDLE;
                    if (HREADY) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ERR2;
                    end
                end else if (HREADY) begin
                    if (!hwrite_q) begin
                        rd_data_d  = HRDATA;
                        rd_valid_d = 1'b1;
                    end
                    if (state_q == S_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_ERR2: begin
                if (HREADY) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (hwrite_q) hwdata_d = wr_data;
            if (beats_left_q == 5'd0) begin
                htrans_d = TR_IDLE;
                state_d  = S_LAST;
            end else begin
                haddr_d      = next_addr_c;
                htrans_d     = next_trans_c;
                beats_left_d = beats_left_q - 5'd1;
                state_d      = S_BURST;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= S_IDLE;
            haddr_q      <= '0;
            htrans_q     <= TR_IDLE;
            hburst_q     <= 3'b000;
            hsize_q      <= 3'b000;
            hwrite_q     <= 1'b0;
            hwdata_q     <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wrap_q       <= 1'b0;
            wrap_mask_q  <= '0;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            haddr_q      <= haddr_d;
            htrans_q     <= htrans_d;
            hburst_q     <= hburst_d;
            hsize_q      <= hsize_d;
            hwrite_q     <= hwrite_d;
            hwdata_q     <= hwdata_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
            wrap_q       <= wrap_d;
            wrap_mask_q  <= wrap_mask_d;
            beats_left_q <= beats_left_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign wr_data_ack = hwrite_q && HREADY && !HRESP && !HRESET && (htrans_q != TR_IDLE);
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign done        = done_q;
    assign err         = err_q;
    assign HADDR       = haddr_q;
    assign HTRANS      = htrans_q;
    assign HBURST      = hburst_q;
    assign HSIZE       = hsize_q;
    assign HWRITE      = hwrite_q;
    assign HWDATA      = hwdata_q;
endmodule
